// File: rtl/stream_fifo_pkg.sv
// Shared constants and output-FSM state type for the receive-side byte FIFO.
package stream_fifo_pkg;

    localparam logic TRUE    = 1'b1;
    localparam logic FALSE   = 1'b0;
    localparam logic TRUE_n  = 1'b0;
    localparam logic FALSE_n = 1'b1;

    typedef enum logic [1:0] {
        OUT_IDLE    = 2'd0,
        OUT_PRESENT = 2'd1,
        OUT_GAP     = 2'd2
    } out_state_e;

endpackage

// File: rtl/fifo_ram_8.sv
// Byte-wide storage: synchronous write, asynchronous read, no reset (maps to distributed RAM).
module fifo_ram_8 #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [7:0]            wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [7:0]            rdata
);

    logic [7:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Byte FIFO between the serial receiver and terminal_stream: absorbs bursts, re-times bytes
// into spaced single-cycle strobes and throttles the host through rts_n with hysteresis.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int RTS_HIGH   = 48,
    parameter int RTS_LOW    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  ready_n,
    output logic [7:0]            unicode,
    output logic                  unicode_available,
    output logic                  rts_n,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   level,
    output out_state_e            out_state
);

    // Handshakes: in_valid is a 1-cycle strobe with no back-pressure (rts_n only asks the
    // host to pause; a byte arriving while full is dropped). On the output side ready_n is
    // sampled only in OUT_IDLE, and each accepted byte yields one unicode_available pulse.

    localparam int                  DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L    = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] RTS_HIGH_L = (ADDR_WIDTH + 1)'(RTS_HIGH);
    localparam logic [ADDR_WIDTH:0] RTS_LOW_L  = (ADDR_WIDTH + 1)'(RTS_LOW);
    localparam logic [ADDR_WIDTH:0] LEVEL_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;
    logic [ADDR_WIDTH:0]   level_next;
    logic [7:0]            rd_data;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    out_state_e            state;
    out_state_e            state_next;

    assign full      = (level == DEPTH_L);
    assign empty     = (level == '0);
    // A pop in the same cycle never frees room for a push into a full FIFO.
    assign push      = in_valid && !full;
    assign out_state = state;

    fifo_ram_8 #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (tail),
        .wdata (in_data),
        .raddr (head),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= OUT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // OUT_GAP covers terminal_stream's one-cycle lag in updating ready_n after a byte.
    always_comb begin
        state_next = state;
        pop        = FALSE;
        case (state)
            OUT_IDLE: begin
                if (!empty && ready_n == TRUE_n) begin
                    pop        = TRUE;
                    state_next = OUT_PRESENT;
                end
            end
            OUT_PRESENT: state_next = OUT_GAP;
            OUT_GAP:     state_next = OUT_IDLE;
            default:     state_next = OUT_IDLE;
        endcase
    end

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LEVEL_ONE;
            2'b01:   level_next = level - LEVEL_ONE;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head              <= '0;
            tail              <= '0;
            level             <= '0;
            unicode           <= 8'h00;
            unicode_available <= FALSE;
            rts_n             <= TRUE_n;
            overflow          <= FALSE;
        end else begin
            level             <= level_next;
            unicode_available <= pop;
            if (push) begin
                tail <= tail + PTR_ONE;
            end
            if (pop) begin
                head    <= head + PTR_ONE;
                unicode <= rd_data;
            end
            if (in_valid && full) begin
                overflow <= TRUE;
            end
            // Hysteresis on the level the FIFO will hold after this edge.
            if (level_next >= RTS_HIGH_L) begin
                rts_n <= FALSE_n;
            end else if (level_next <= RTS_LOW_L) begin
                rts_n <= TRUE_n;
            end
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: queue-based reference model plus directed scenarios.
module tb_stream_fifo;
    import stream_fifo_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       ready_n;
    logic [7:0] unicode;
    logic       unicode_available;
    logic       rts_n;
    logic       overflow;
    logic [6:0] level;
    out_state_e out_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    stream_fifo dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .ready_n           (ready_n),
        .unicode           (unicode),
        .unicode_available (unicode_available),
        .rts_n             (rts_n),
        .overflow          (overflow),
        .level             (level),
        .out_state         (out_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Byte queue plus "cycles since last strobe"; a strobe may go out once 3 cycles have passed.
    logic [7:0] exp_q[$];
    logic [7:0] m_unicode;
    logic       m_avail;
    logic       m_rts_n;
    logic       m_overflow;
    int         m_since;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
            m_unicode  <= 8'h00;
            m_avail    <= 1'b0;
            m_rts_n    <= 1'b0;
            m_overflow <= 1'b0;
            m_since    = 3;
        end else begin
            int  sz;
            bit  was_full;
            was_full = (exp_q.size() == 64);
            if (m_since >= 3 && !ready_n && exp_q.size() != 0) begin
                m_unicode <= exp_q.pop_front();
                m_avail   <= 1'b1;
                m_since   = 1;
            end else begin
                m_avail <= 1'b0;
                if (m_since < 3) m_since = m_since + 1;
            end
            if (in_valid) begin
                if (was_full) m_overflow <= 1'b1;
                else          exp_q.push_back(in_data);
            end
            sz = exp_q.size();
            if (sz >= 48)      m_rts_n <= 1'b1;
            else if (sz <= 16) m_rts_n <= 1'b0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            check("level", 32'(level), 32'(exp_q.size()));
            check("unicode_available", 32'(unicode_available), 32'(m_avail));
            check("unicode", 32'(unicode), 32'(m_unicode));
            check("rts_n", 32'(rts_n), 32'(m_rts_n));
            check("overflow", 32'(overflow), 32'(m_overflow));
        end
    end

    // Strobe log for the directed scenarios.
    logic [7:0] log_byte[$];
    int         log_cyc[$];

    always @(negedge clk) begin
        if (reset_n && unicode_available) begin
            log_byte.push_back(unicode);
            log_cyc.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        log_byte.delete();
        log_cyc.delete();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int   rts_rise_lvl;
        int   rts_fall_lvl;
        int   bad;
        int   pushed;
        int   guard;
        logic [7:0] pat[$];

        reset_n  = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        ready_n  = 1'b1;
        run(3);
        reset_n = 1'b1;
        step();

        // 1. reset mid-burst
        for (int i = 0; i < 5; i++) push_byte(8'(8'h30 + i));
        check("burst_level", 32'(level), 32'd5);
        ready_n = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_avail", 32'(unicode_available), 32'd0);
        check("rst_rts_n", 32'(rts_n), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_unicode", 32'(unicode), 32'h00);
        check("rst_state", 32'(out_state), 32'(OUT_IDLE));
        step();
        reset_n = 1'b1;
        log_byte.delete();
        log_cyc.delete();
        run(10);
        check("rst_no_strobe", 32'(log_byte.size()), 32'd0);

        // 2. pass-through latency
        do_reset();
        ready_n = 1'b0;
        push_byte(8'h41);
        check("pt_avail_c1", 32'(unicode_available), 32'd0);
        step();
        check("pt_avail_c2", 32'(unicode_available), 32'd1);
        check("pt_unicode", 32'(unicode), 32'h41);
        step();
        check("pt_avail_c3", 32'(unicode_available), 32'd0);
        check("pt_level", 32'(level), 32'd0);
        run(5);
        check("pt_strobe_count", 32'(log_byte.size()), 32'd1);

        // 3. back-pressure then release
        do_reset();
        ready_n = 1'b1;
        push_byte("A");
        push_byte("B");
        push_byte("C");
        run(6);
        check("bp_no_strobe", 32'(log_byte.size()), 32'd0);
        ready_n = 1'b0;
        run(12);
        check("bp_count", 32'(log_byte.size()), 32'd3);
        if (log_byte.size() == 3) begin
            check("bp_byte0", 32'(log_byte[0]), 32'h41);
            check("bp_byte1", 32'(log_byte[1]), 32'h42);
            check("bp_byte2", 32'(log_byte[2]), 32'h43);
            check("bp_gap01", 32'(log_cyc[1] - log_cyc[0]), 32'd3);
            check("bp_gap12", 32'(log_cyc[2] - log_cyc[1]), 32'd3);
        end

        // 4. fill, overflow, drain
        do_reset();
        ready_n = 1'b1;
        rts_rise_lvl = -1;
        pat.delete();
        for (int i = 0; i < 64; i++) begin
            pat.push_back(8'(i * 7 + 3));
            push_byte(8'(i * 7 + 3));
            if (rts_rise_lvl < 0 && rts_n) rts_rise_lvl = int'(level);
        end
        check("fill_level", 32'(level), 32'd64);
        check("fill_rts_n", 32'(rts_n), 32'd1);
        check("rts_rise_level", 32'(rts_rise_lvl), 32'd48);
        check("fill_no_ovf", 32'(overflow), 32'd0);
        push_byte(8'hEE);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_level", 32'(level), 32'd64);
        ready_n = 1'b0;
        rts_fall_lvl = -1;
        guard = 0;
        while (level != 0 && guard < 400) begin
            step();
            guard++;
            if (rts_fall_lvl < 0 && !rts_n) rts_fall_lvl = int'(level);
        end
        check("drain_timeout", 32'(guard < 400), 32'd1);
        run(4);
        check("rts_fall_level", 32'(rts_fall_lvl), 32'd16);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("drain_count", 32'(log_byte.size()), 32'd64);
        bad = 0;
        for (int i = 0; i < 64 && i < log_byte.size(); i++)
            if (log_byte[i] !== pat[i]) bad++;
        check("drain_bytes_intact", 32'(bad), 32'd0);

        // 5. wrap-around random traffic, never full
        do_reset();
        pushed = 0;
        guard  = 0;
        while (pushed < 200 && guard < 5000) begin
            ready_n = 1'($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0 && level < 60) begin
                in_data  = 8'($urandom_range(0, 255));
                in_valid = 1'b1;
                pushed++;
            end else begin
                in_valid = 1'b0;
            end
            step();
            guard++;
        end
        in_valid = 1'b0;
        ready_n  = 1'b0;
        check("rand_push_timeout", 32'(pushed), 32'd200);
        guard = 0;
        while (level != 0 && guard < 1000) begin
            step();
            guard++;
        end
        run(4);
        check("rand_drained", 32'(level), 32'd0);
        check("rand_count", 32'(log_byte.size()), 32'd200);
        check("rand_no_ovf", 32'(overflow), 32'd0);

        // 6. simultaneous push and pop at level 1
        do_reset();
        ready_n = 1'b1;
        push_byte(8'h11);
        check("sim_pre_level", 32'(level), 32'd1);
        ready_n = 1'b0;
        push_byte(8'h22);
        check("sim_level", 32'(level), 32'd1);
        check("sim_avail", 32'(unicode_available), 32'd1);
        check("sim_unicode", 32'(unicode), 32'h11);
        run(6);
        check("sim_count", 32'(log_byte.size()), 32'd2);
        if (log_byte.size() == 2) begin
            check("sim_order0", 32'(log_byte[0]), 32'h11);
            check("sim_order1", 32'(log_byte[1]), 32'h22);
        end
        check("sim_final_level", 32'(level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
